// File: rtl/lives_manager.sv
// Lives/hit FSM for the frog: PLAY -> INVULN grace period -> PLAY, or PLAY -> GAME_OVER.
// Optional macro LIVES_EXTRA_LIFE_EN adds the level_up input (extra life, saturating at 3).
// Handshake: none; collision is a level and only its registered rising edge is a hit.
// state_dbg encoding: 0 = PLAY, 1 = INVULN, 2 = GAME_OVER.
module lives_manager #(
  parameter int INIT_LIVES    = 3,
  parameter int INVULN_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       collision,
  input  logic       reset_lives,
`ifdef LIVES_EXTRA_LIFE_EN
  input  logic       level_up,
`endif
  output logic [1:0] lives,
  output logic       reset_level,
  output logic       hit_pulse,
  output logic       invulnerable,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } state_e;

  localparam int            TW         = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(INVULN_CYCLES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(INIT_LIVES);

  state_e        state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          hit_pulse_q, hit_pulse_d;
  logic          coll_q;
  logic          armed_q;
  logic          hit;
  logic          lvl_up;

`ifdef LIVES_EXTRA_LIFE_EN
  assign lvl_up = level_up;
`else
  assign lvl_up = 1'b0;
`endif

  // armed_q blocks the first post-reset cycle so a collision held through reset never counts.
  assign hit = collision & ~coll_q & armed_q;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    timer_d     = timer_q;
    hit_pulse_d = 1'b0;
    if (reset_lives) begin
      state_d = PLAY;
      lives_d = LIVES_INIT;
      timer_d = '0;
    end else begin
      case (state_q)
        PLAY: begin
          if (hit) begin
            hit_pulse_d = 1'b1;
            // A simultaneous extra life cancels the loss but the grace period still starts.
            if (lvl_up) begin
              timer_d = TIMER_LOAD;
              state_d = INVULN;
            end else if (lives_q > 2'd1) begin
              lives_d = lives_q - 2'd1;
              timer_d = TIMER_LOAD;
              state_d = INVULN;
            end else begin
              lives_d = 2'd0;
              state_d = GAME_OVER;
            end
          end else if (lvl_up && lives_q != 2'd3) begin
            lives_d = lives_q + 2'd1;
          end
        end
        INVULN: begin
          if (timer_q == '0) begin
            state_d = PLAY;
          end else begin
            timer_d = timer_q - TW'(1);
          end
          if (lvl_up && lives_q != 2'd3) begin
            lives_d = lives_q + 2'd1;
          end
        end
        GAME_OVER: begin
          lives_d = 2'd0;
        end
        default: begin
          state_d = PLAY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLAY;
      lives_q     <= LIVES_INIT;
      timer_q     <= '0;
      hit_pulse_q <= 1'b0;
      coll_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      timer_q     <= timer_d;
      hit_pulse_q <= hit_pulse_d;
      coll_q      <= collision;
      armed_q     <= 1'b1;
    end
  end

  assign lives        = lives_q;
  assign hit_pulse    = hit_pulse_q;
  assign invulnerable = (state_q == INVULN);
  assign reset_level  = (state_q == GAME_OVER);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_lives_manager.sv
// Directed bench for lives_manager (INIT_LIVES=3, INVULN_CYCLES=4): the driver queues the
// expected registered outputs after each clock edge, a negedge monitor pops and compares them.
module tb_lives_manager;

  localparam int W = 7;  // {state_dbg[1:0], lives[1:0], reset_level, hit_pulse, invulnerable}

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       collision   = 1'b0;
  logic       reset_lives = 1'b0;
`ifdef LIVES_EXTRA_LIFE_EN
  logic       level_up    = 1'b0;
`endif
  logic [1:0] lives;
  logic [1:0] state_dbg;
  logic       reset_level;
  logic       hit_pulse;
  logic       invulnerable;
  logic [W-1:0] obs;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];

  lives_manager #(
    .INIT_LIVES   (3),
    .INVULN_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .collision   (collision),
    .reset_lives (reset_lives),
`ifdef LIVES_EXTRA_LIFE_EN
    .level_up    (level_up),
`endif
    .lives       (lives),
    .reset_level (reset_level),
    .hit_pulse   (hit_pulse),
    .invulnerable(invulnerable),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  assign obs = {state_dbg, lives, reset_level, hit_pulse, invulnerable};

  function automatic logic [W-1:0] pack_exp(input logic [1:0] lv, input logic rl,
                                            input logic hp, input logic inv);
    logic [1:0] st;
    st = rl ? 2'd2 : (inv ? 2'd1 : 2'd0);
    return {st, lv, rl, hp, inv};
  endfunction

  task automatic compare(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b required %b (state,lives,reset_level,hit_pulse,invulnerable)",
               nm, act, exp);
    end
  endtask

  // Driver: called at a negedge; drives inputs, queues the outcome of the next rising edge.
  task automatic step(input logic c, input logic rl, input logic [1:0] lv, input logic erl,
                      input logic hp, input logic inv, input string nm);
    collision   = c;
    reset_lives = rl;
    @(posedge clk);
    exp_q.push_back(pack_exp(lv, erl, hp, inv));
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  // One fresh hit from PLAY with lives > 1, then the full 4-cycle grace period.
  task automatic hit_cycle(input logic [1:0] lv);
    step(1'b1, 1'b0, lv, 1'b0, 1'b1, 1'b1, "hit");
    repeat (3) step(1'b0, 1'b0, lv, 1'b0, 1'b0, 1'b1, "invuln");
    step(1'b0, 1'b0, lv, 1'b0, 1'b0, 1'b0, "back_to_play");
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      compare(name_q.pop_front(), obs, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required normal completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values while held, with collision already high.
    collision = 1'b1;
    repeat (2) @(negedge clk);
    compare("reset_vals", obs, pack_exp(2'd3, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;

    // Collision held across reset release never counts.
    repeat (3) step(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, "held_thru_rst");
    step(1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, "idle");

    // Single pulse: 3 -> 2, grace period of exactly 4 cycles.
    hit_cycle(2'd2);

    // Collision held 20 cycles: one decrement only, no retrigger on return to PLAY.
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, "restart1");
    step(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, "held_hit");
    for (int i = 1; i < 20; i++) begin
      step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, (i <= 3) ? 1'b1 : 1'b0, "held_no_retrigger");
    end
    step(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, "held_release");

    // Three spaced hits: 3 -> 2 -> 1 -> 0 and GAME_OVER, which holds.
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, "restart2");
    hit_cycle(2'd2);
    hit_cycle(2'd1);
    step(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, "fatal_hit");
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "go_hold");
    step(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "go_ignore_hit");
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "go_hold2");
    step(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "go_ignore_hit2");
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "go_hold3");

    // Restart out of GAME_OVER.
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, "go_restart");
    step(1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, "go_after");

    // reset_lives beats a same-cycle hit at lives == 1.
    hit_cycle(2'd2);
    hit_cycle(2'd1);
    step(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, "rl_vs_hit");
    step(1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, "rl_vs_hit_after");

    // reset_lives in the middle of INVULN.
    step(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, "hit_before_rl");
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, "rl_in_invuln");
    step(1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, "rl_in_invuln_after");

    // A fresh edge during INVULN is ignored.
    step(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, "hit_inv_test");
    step(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, "inv_t2");
    step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, "inv_ignore");
    step(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, "inv_t0");
    step(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, "inv_done");

    // Asynchronous reset mid-INVULN at lives == 2.
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, "restart3");
    step(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, "pre_async");
    collision = 1'b0;
    #2 rst_n = 1'b0;
    #1 compare("async_rst", obs, pack_exp(2'd3, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    compare("rst_held", obs, pack_exp(2'd3, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    step(1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, "post_rst_idle");
    step(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, "post_rst_edge");
    step(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, "post_rst_inv");

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
